// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//
// Fetch-stage branch predictor. Holds the registered fetch PC and predicts
// the next PC from an NWAYS-way set-associative branch target buffer. Each
// BTB entry has a valid bit, a tag, a target and a saturating direction
// counter. Each set has a round-robin replacement pointer. Resolved branches
// from execute train the BTB. A misprediction redirects fetch to the correct
// PC on the next cycle and bumps a saturating 16-bit mispredict counter.
//
// Ports
//   clk               in   clock, rising edge
//   reset_n           in   synchronous, active-low reset
//   i_stall           in   hold fetch PC (ignored during a redirect)
//   o_pc              out  registered fetch PC
//   o_btb_hit         out  valid tag match for o_pc in its set
//   o_pred_taken      out  hit and MSB of the matching direction counter
//   o_pred_target     out  matching target on a hit, else 0
//   i_upd_valid       in   execute resolved a branch this cycle
//   i_upd_pc          in   resolved branch PC
//   i_upd_target      in   resolved taken target
//   i_upd_taken       in   actual outcome
//   i_upd_pred_taken  in   direction predicted for this branch
//   i_upd_pred_target in   target predicted for this branch
//   o_mispredict      out  combinational redirect flag
//   o_mispredict_cnt  out  saturating mispredict count
// ---------------------------------------------------------------------------
module btb_predictor #(
    parameter int              NSETS    = 16,
    parameter int              NWAYS    = 2,
    parameter int              PC_W     = 16,
    parameter int              CNT_W    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_stall,
    output logic [PC_W-1:0] o_pc,
    output logic            o_btb_hit,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic [PC_W-1:0] i_upd_target,
    input  logic            i_upd_taken,
    input  logic            i_upd_pred_taken,
    input  logic [PC_W-1:0] i_upd_pred_target,
    output logic            o_mispredict,
    output logic [15:0]     o_mispredict_cnt
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = PC_W - IDX_W;
    localparam int WAY_W = (NWAYS > 1) ? $clog2(NWAYS) : 1;

    // New allocations start weakly taken: MSB set, remaining bits clear.
    localparam logic [CNT_W-1:0] WEAK_TAKEN = {1'b1, {(CNT_W-1){1'b0}}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // BTB state
    logic             r_valid  [NSETS][NWAYS];
    logic [TAG_W-1:0] r_tag    [NSETS][NWAYS];
    logic [PC_W-1:0]  r_target [NSETS][NWAYS];
    logic [CNT_W-1:0] r_cnt    [NSETS][NWAYS];
    logic [WAY_W-1:0] r_rr     [NSETS];

    logic [PC_W-1:0]  r_pc;
    logic [15:0]      r_mp_cnt;

    // ---- fetch-side lookup ----
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;

    assign w_idx = r_pc[IDX_W-1:0];
    assign w_tag = r_pc[PC_W-1:IDX_W];

    // Scan from the top way down so that the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign o_btb_hit     = w_hit;
    assign o_pred_taken  = w_hit && r_cnt[w_idx][w_hit_way][CNT_W-1];
    assign o_pred_target = w_hit ? r_target[w_idx][w_hit_way] : '0;

    // ---- update-side lookup and victim selection ----
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [WAY_W-1:0] w_u_hit_way;
    logic             w_u_has_inv;
    logic [WAY_W-1:0] w_u_inv_way;
    logic [WAY_W-1:0] w_u_victim;
    logic [WAY_W-1:0] w_u_rr_next;

    assign w_u_idx = i_upd_pc[IDX_W-1:0];
    assign w_u_tag = i_upd_pc[PC_W-1:IDX_W];

    always_comb begin
        w_u_hit     = 1'b0;
        w_u_hit_way = '0;
        w_u_has_inv = 1'b0;
        w_u_inv_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
                w_u_hit     = 1'b1;
                w_u_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_u_idx][w]) begin
                w_u_has_inv = 1'b1;
                w_u_inv_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways are filled first; the round-robin pointer only moves
    // when a valid entry has to be evicted.
    assign w_u_victim  = w_u_has_inv ? w_u_inv_way : r_rr[w_u_idx];
    assign w_u_rr_next = (r_rr[w_u_idx] == WAY_W'(NWAYS - 1)) ? '0
                                                              : r_rr[w_u_idx] + WAY_W'(1);

    // ---- misprediction and next PC ----
    logic [PC_W-1:0] w_correct_pc;
    logic [PC_W-1:0] w_next_pc;

    assign o_mispredict = i_upd_valid &&
                          ((i_upd_taken != i_upd_pred_taken) ||
                           (i_upd_taken && (i_upd_target != i_upd_pred_target)));

    assign w_correct_pc = i_upd_taken ? i_upd_target : i_upd_pc + PC_W'(1);

    always_comb begin
        if (o_mispredict)
            w_next_pc = w_correct_pc;
        else if (i_stall)
            w_next_pc = r_pc;
        else if (o_pred_taken)
            w_next_pc = o_pred_target;
        else
            w_next_pc = r_pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_mp_cnt <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (o_mispredict && (r_mp_cnt != 16'hFFFF))
                r_mp_cnt <= r_mp_cnt + 16'd1;
        end
    end

    assign o_pc             = r_pc;
    assign o_mispredict_cnt = r_mp_cnt;

    // ---- BTB training ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < NSETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < NWAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_cnt[s][w]    <= '0;
                end
            end
        end else if (i_upd_valid) begin
            if (w_u_hit) begin
                if (i_upd_taken) begin
                    r_cnt[w_u_idx][w_u_hit_way]    <= sat_inc(r_cnt[w_u_idx][w_u_hit_way]);
                    r_target[w_u_idx][w_u_hit_way] <= i_upd_target;
                end else begin
                    r_cnt[w_u_idx][w_u_hit_way]    <= sat_dec(r_cnt[w_u_idx][w_u_hit_way]);
                end
            end else if (i_upd_taken) begin
                r_valid[w_u_idx][w_u_victim]  <= 1'b1;
                r_tag[w_u_idx][w_u_victim]    <= w_u_tag;
                r_target[w_u_idx][w_u_victim] <= i_upd_target;
                r_cnt[w_u_idx][w_u_victim]    <= WEAK_TAKEN;
                if (!w_u_has_inv)
                    r_rr[w_u_idx] <= w_u_rr_next;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// ---------------------------------------------------------------------------
// tb_btb_predictor
//
// Directed bench for btb_predictor with default parameters
// (NSETS=16, NWAYS=2, PC_W=16, CNT_W=2, RESET_PC=0).
// ---------------------------------------------------------------------------
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [15:0] pc;
    logic        btb_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] mispredict_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btb_predictor dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_stall           (stall),
        .o_pc              (pc),
        .o_btb_hit         (btb_hit),
        .o_pred_taken      (pred_taken),
        .o_pred_target     (pred_target),
        .i_upd_valid       (upd_valid),
        .i_upd_pc          (upd_pc),
        .i_upd_target      (upd_target),
        .i_upd_taken       (upd_taken),
        .i_upd_pred_taken  (upd_pred_taken),
        .i_upd_pred_target (upd_pred_target),
        .o_mispredict      (mispredict),
        .o_mispredict_cnt  (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [15:0] p, input logic [15:0] t,
                       input logic tk, input logic ptk, input logic [15:0] pt);
        upd_valid       = v;
        upd_pc          = p;
        upd_target      = t;
        upd_taken       = tk;
        upd_pred_taken  = ptk;
        upd_pred_target = pt;
        #1;
    endtask

    // Not-taken branch at p that was predicted taken: redirect to p+1.
    task automatic redirect(input logic [15:0] p);
        upd(1'b1, p, 16'h0, 1'b0, 1'b1, 16'h0);
        tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_hit", btb_hit, 32'h0);
        chk("reset_pred_taken", pred_taken, 32'h0);
        chk("reset_pred_target", pred_target, 32'h0);
        chk("reset_mp_cnt", mispredict_cnt, 32'h0);
        chk("reset_mispredict", mispredict, 32'h0);

        // Sequential fetch with an empty BTB
        reset_n = 1'b1;
        tick(); chk("seq_pc1", pc, 32'h1); chk("seq_hit1", btb_hit, 32'h0);
        tick(); chk("seq_pc2", pc, 32'h2); chk("seq_hit2", btb_hit, 32'h0);
        tick(); chk("seq_pc3", pc, 32'h3); chk("seq_hit3", btb_hit, 32'h0);
        chk("seq_mp_cnt", mispredict_cnt, 32'h0);

        // Taken branch at 0x5 predicted not-taken: allocate + redirect
        upd(1'b1, 16'h0005, 16'h0020, 1'b1, 1'b0, 16'h0);
        chk("alloc_mispredict", mispredict, 32'h1);
        tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("alloc_redirect_pc", pc, 32'h20);
        chk("alloc_mp_cnt", mispredict_cnt, 32'h1);
        chk("idle_mispredict", mispredict, 32'h0);

        redirect(16'h0004);
        chk("hit5_pc", pc, 32'h5);
        chk("hit5_hit", btb_hit, 32'h1);
        chk("hit5_pred_taken", pred_taken, 32'h1);
        chk("hit5_pred_target", pred_target, 32'h20);
        tick();
        chk("hit5_next_pc", pc, 32'h20);

        // Three not-taken updates: counter 10 -> 01 -> 00 -> 00
        upd(1'b1, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("nt_no_mispredict", mispredict, 32'h0);
        tick(); tick(); tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("nt_pc", pc, 32'h23);
        redirect(16'h0004);
        chk("nt_hit", btb_hit, 32'h1);
        chk("nt_pred_taken", pred_taken, 32'h0);
        chk("nt_pred_target", pred_target, 32'h20);
        tick();
        chk("nt_next_pc", pc, 32'h6);

        // Fill set 5: 0x05 hit (target rewrite), 0x15 to way 1, 0x25 evicts way 0
        upd(1'b1, 16'h0005, 16'h0030, 1'b1, 1'b1, 16'h0030); tick();
        upd(1'b1, 16'h0015, 16'h0040, 1'b1, 1'b1, 16'h0040); tick();
        upd(1'b1, 16'h0025, 16'h0050, 1'b1, 1'b1, 16'h0050); tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("fill_pc", pc, 32'h9);
        chk("fill_mp_cnt", mispredict_cnt, 32'h3);
        redirect(16'h0004);
        chk("evict5_hit", btb_hit, 32'h0);
        chk("evict5_pred_taken", pred_taken, 32'h0);
        chk("evict5_pred_target", pred_target, 32'h0);
        tick();
        chk("evict5_next_pc", pc, 32'h6);
        redirect(16'h0014);
        chk("way15_hit", btb_hit, 32'h1);
        chk("way15_pred_taken", pred_taken, 32'h1);
        chk("way15_pred_target", pred_target, 32'h40);
        tick();
        chk("way15_next_pc", pc, 32'h40);
        redirect(16'h0024);
        chk("way25_hit", btb_hit, 32'h1);
        chk("way25_pred_target", pred_target, 32'h50);

        // Round-robin pointer now at way 1: 0x35 evicts 0x15
        upd(1'b1, 16'h0035, 16'h0060, 1'b1, 1'b1, 16'h0060);
        tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("rr_pred_pc", pc, 32'h50);
        redirect(16'h0014);
        chk("rr15_hit", btb_hit, 32'h0);
        redirect(16'h0024);
        chk("rr25_hit", btb_hit, 32'h1);
        chk("rr25_pred_target", pred_target, 32'h50);
        redirect(16'h0034);
        chk("rr35_hit", btb_hit, 32'h1);
        chk("rr35_pred_target", pred_target, 32'h60);
        chk("rr_mp_cnt", mispredict_cnt, 32'h9);

        // Mispredict overrides stall, then stall holds pc
        stall = 1'b1;
        upd(1'b1, 16'h003F, 16'h0040, 1'b1, 1'b0, 16'h0);
        tick();
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("stall_redirect_pc", pc, 32'h40);
        tick(); chk("stall_hold1", pc, 32'h40);
        tick(); chk("stall_hold2", pc, 32'h40);
        stall = 1'b0;
        tick(); chk("stall_release", pc, 32'h41);
        chk("stall_mp_cnt", mispredict_cnt, 32'hA);

        // upd_pc+1 wraps modulo 2^16
        redirect(16'hFFFF);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_mp_cnt", mispredict_cnt, 32'hB);

        // Reset mid-run discards a concurrent update
        reset_n = 1'b0;
        upd(1'b1, 16'h0007, 16'h0070, 1'b1, 1'b0, 16'h0);
        tick();
        reset_n = 1'b1;
        upd(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_mp_cnt", mispredict_cnt, 32'h0);
        chk("rst2_hit0", btb_hit, 32'h0);
        redirect(16'h0004);
        chk("rst2_hit5", btb_hit, 32'h0);
        redirect(16'h0024);
        chk("rst2_hit25", btb_hit, 32'h0);
        redirect(16'h0006);
        chk("rst2_hit7", btb_hit, 32'h0);
        chk("rst2_pc7", pc, 32'h7);
        chk("rst2_mp_cnt_end", mispredict_cnt, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
